isa_io_cycle: RTL

ISA I/O cycle engine that sits directly downstream of the DSP sequencer blocks (reset sequence, command writers). It samples the sequencer's requested address, write data and direction, and runs one complete ISA I/O read or write cycle on the riser bus: AEN, SA, SD drive, IOR#/IOW# strobe timing and IOCHRDY wait states. When the cycle completes it returns read data and pulses bus_clock, which the sequencer uses to advance its state.

---
 rtl/isa_io_cycle.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/isa_io_cycle.sv
// ISA I/O cycle engine: runs one AEN/SA/SD/IOR#/IOW# cycle per captured sequencer request.
// Latency: 1+SETUP+STROBE+HOLD+1 sys_clock cycles without wait states, plus IOCHRDY extension.
// Backpressure: IOCHRDY low stretches the strobe up to READY_TIMEOUT cycles, then the cycle is abandoned.
module isa_io_cycle #(
  parameter int SETUP_CYCLES  = 4,
  parameter int STROBE_CYCLES = 8,
  parameter int HOLD_CYCLES   = 2,
  parameter int READY_TIMEOUT = 255
) (
  input  logic        sys_clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] req_address,
  input  logic [15:0] req_data,
  input  logic        req_dir,
  input  logic [15:0] isa_sd_in,
  input  logic        isa_iochrdy,
  output logic [15:0] isa_sa,
  output logic [15:0] isa_sd_out,
  output logic        isa_sd_oe,
  output logic        isa_ior_n,
  output logic        isa_iow_n,
  output logic        isa_aen,
  output logic [15:0] data_in,
  output logic        bus_clock,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_STROBE   = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_HOLD     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LD = 8'(READY_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic [15:0] sa_q, sa_d;
  logic [15:0] sd_out_q, sd_out_d;
  logic        sd_oe_q, sd_oe_d;
  logic        ior_n_q, ior_n_d;
  logic        iow_n_q, iow_n_d;
  logic        aen_q, aen_d;
  logic [15:0] data_in_q, data_in_d;
  logic        bus_clock_q, bus_clock_d;
  logic        busy_q, busy_d;
  logic        timeout_err_q, timeout_err_d;

  // Next-state and next-output logic; every output is computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    sa_d          = sa_q;
    sd_out_d      = sd_out_q;
    sd_oe_d       = sd_oe_q;
    ior_n_d       = ior_n_q;
    iow_n_d       = iow_n_q;
    aen_d         = aen_q;
    data_in_d     = data_in_q;
    bus_clock_d   = 1'b0;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (enable) begin
          // Request is captured only here; later req_* changes cannot disturb the cycle.
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          dir_d   = req_dir;
          sa_d    = req_address;
          aen_d   = 1'b0;
          busy_d  = 1'b1;
          if (req_dir) begin
            sd_out_d = req_data;
            sd_oe_d  = 1'b1;
          end
        end
      end

      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
          ior_n_d = dir_q;
          iow_n_d = ~dir_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_STROBE: begin
        if (cnt_q == 8'd0) begin
          if (isa_iochrdy) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
            ior_n_d = 1'b1;
            iow_n_d = 1'b1;
            if (!dir_q) data_in_d = isa_sd_in;
          end else begin
            state_d = S_WAIT_RDY;
            cnt_d   = TIMEOUT_LD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_WAIT_RDY: begin
        if (isa_iochrdy) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
          ior_n_d = 1'b1;
          iow_n_d = 1'b1;
          if (!dir_q) data_in_d = isa_sd_in;
        end else if (cnt_q == 8'd0) begin
          // Target never became ready: abandon the cycle and poison read data.
          state_d       = S_HOLD;
          cnt_d         = HOLD_LD;
          ior_n_d       = 1'b1;
          iow_n_d       = 1'b1;
          timeout_err_d = 1'b1;
          if (!dir_q) data_in_d = 16'hFFFF;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d     = S_DONE;
          cnt_d       = 8'd0;
          bus_clock_d = 1'b1;
          aen_d       = 1'b1;
          sd_oe_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        ior_n_d = 1'b1;
        iow_n_d = 1'b1;
        aen_d   = 1'b1;
        sd_oe_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset releases the strobes and the bus immediately.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      dir_q         <= 1'b0;
      sa_q          <= 16'h0000;
      sd_out_q      <= 16'h0000;
      sd_oe_q       <= 1'b0;
      ior_n_q       <= 1'b1;
      iow_n_q       <= 1'b1;
      aen_q         <= 1'b1;
      data_in_q     <= 16'h0000;
      bus_clock_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      sa_q          <= sa_d;
      sd_out_q      <= sd_out_d;
      sd_oe_q       <= sd_oe_d;
      ior_n_q       <= ior_n_d;
      iow_n_q       <= iow_n_d;
      aen_q         <= aen_d;
      data_in_q     <= data_in_d;
      bus_clock_q   <= bus_clock_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign isa_sa      = sa_q;
  assign isa_sd_out  = sd_out_q;
  assign isa_sd_oe   = sd_oe_q;
  assign isa_ior_n   = ior_n_q;
  assign isa_iow_n   = iow_n_q;
  assign isa_aen     = aen_q;
  assign data_in     = data_in_q;
  assign bus_clock   = bus_clock_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
